// File: rtl/free_list_pkg.sv
// Shared sizing constants, reserved tag values and control states for the
// physical-register free list.
package free_list_pkg;

    localparam int PREG_W     = 8;
    localparam int NUM_PREG   = 256;
    localparam int NUM_ARCH   = 32;
    localparam int NUM_PAGES  = 8;
    localparam int INIT_COUNT = 222;
    localparam int PTR_W      = PREG_W + 1;
    localparam int PAGE_W     = $clog2(NUM_PAGES);

    localparam logic [PREG_W-1:0] TAG_IMM  = 8'd254;
    localparam logic [PREG_W-1:0] TAG_NONE = 8'd255;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fl_state_t;

endpackage

// File: rtl/free_list_ckpt.sv
// Checkpoint bank: one head snapshot plus a valid bit per page, with a single
// write port and a single combinational read port.
module free_list_ckpt
    import free_list_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [PAGE_W-1:0] wpage,
    input  logic [PTR_W-1:0]  wdata,
    input  logic [PAGE_W-1:0] rpage,
    output logic [PTR_W-1:0]  rdata,
    output logic              rvalid
);

    logic [PTR_W-1:0]     snap [NUM_PAGES];
    logic [NUM_PAGES-1:0] valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (we) begin
            valid[wpage] <= 1'b1;
        end
    end

    // Snapshot contents are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            snap[wpage] <= wdata;
        end
    end

    assign rdata  = snap[rpage];
    assign rvalid = valid[rpage];

endmodule

// File: rtl/free_list.sv
// Physical-register free list: a circular tag buffer filled with the
// non-architectural tags after reset, with head checkpoints for rollback.
module free_list
    import free_list_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_valid,
    output logic [PREG_W-1:0] alloc_tag,
    input  logic              release_valid,
    input  logic [PREG_W-1:0] release_tag,
    input  logic              save_state,
    input  logic [PAGE_W-1:0] save_page,
    input  logic              restore_state,
    input  logic [PAGE_W-1:0] restore_page,
    output logic              ready,
    output logic [PTR_W-1:0]  count,
    output logic              err
);

    localparam logic [PTR_W-1:0] FULL = PTR_W'(NUM_PREG);

    fl_state_t         state, state_next;
    logic [PREG_W-1:0] buffer [NUM_PREG];
    logic [PTR_W-1:0]  head, tail, head_next, tail_next, head_post;
    logic [PTR_W-1:0]  diff, occ;
    logic [PREG_W-1:0] init_idx;
    logic              in_run, init_last, full;
    logic              rel_drop, rel_fire;
    logic              restore_try, restore_fire, alloc_fire, save_fire, err_set;
    logic [PTR_W-1:0]  ck_rdata;
    logic              ck_rvalid;

    assign in_run    = (state == RUN);
    assign init_last = (init_idx == PREG_W'(INIT_COUNT - 1));

    // A stale checkpoint can leave head past what tail allows; occupancy saturates.
    assign diff        = tail - head;
    assign occ         = (diff > FULL) ? FULL : diff;
    assign full        = (occ == FULL);
    assign alloc_valid = in_run && (occ != '0);
    assign alloc_tag   = buffer[head[PREG_W-1:0]];

    assign rel_drop = (release_tag == '0) || (release_tag == TAG_IMM) ||
                      (release_tag == TAG_NONE);
    assign rel_fire = release_valid && in_run && !rel_drop && !full;

    assign restore_try  = restore_state && in_run;
    assign restore_fire = restore_try && ck_rvalid;
    assign alloc_fire   = alloc_req && alloc_valid && !restore_fire;
    assign save_fire    = save_state && in_run && !restore_state;

    assign head_post = head + PTR_W'(alloc_fire);
    assign head_next = restore_fire ? ck_rdata : head_post;
    assign tail_next = (!in_run && init_last) ? PTR_W'(INIT_COUNT)
                                              : tail + PTR_W'(rel_fire);

    assign err_set = (alloc_req && !alloc_valid && !restore_fire)
                  || (release_valid && (!in_run || (!rel_drop && full)))
                  || (restore_try && !ck_rvalid)
                  || (save_state && restore_state)
                  || (restore_fire && ((tail_next - ck_rdata) > FULL));

    free_list_ckpt u_ckpt (
        .clk    (clk),
        .reset  (reset),
        .we     (save_fire),
        .wpage  (save_page),
        .wdata  (head_post),
        .rpage  (restore_page),
        .rdata  (ck_rdata),
        .rvalid (ck_rvalid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && init_last) begin
            state_next = RUN;
        end
    end

    always_comb begin
        ready = 1'b0;
        if (state == RUN) begin
            ready = 1'b1;
        end
    end

    // count lags the pointers by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            init_idx <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= occ;
            if (!in_run) begin
                init_idx <= init_idx + 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!in_run) begin
            buffer[init_idx] <= PREG_W'(NUM_ARCH) + init_idx;
        end else if (rel_fire) begin
            buffer[tail[PREG_W-1:0]] <= release_tag;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [7:0] alloc_tag;
    logic       release_valid;
    logic [7:0] release_tag;
    logic       save_state;
    logic [2:0] save_page;
    logic       restore_state;
    logic [2:0] restore_page;
    logic       ready;
    logic [8:0] count;
    logic       err;

    int checks   = 0;
    int failures = 0;

    free_list dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_req     (alloc_req),
        .alloc_valid   (alloc_valid),
        .alloc_tag     (alloc_tag),
        .release_valid (release_valid),
        .release_tag   (release_tag),
        .save_state    (save_state),
        .save_page     (save_page),
        .restore_state (restore_state),
        .restore_page  (restore_page),
        .ready         (ready),
        .count         (count),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout reached before summary");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit a; bit r; int rt; bit s; int sp; bit rs; int rp;
        bit av; int tag; int cnt; bit e;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(bit a, bit r, int rt, bit s, int sp, bit rs, int rp,
                                bit av, int tag, int cnt, bit e);
        vec_t v;
        v.a = a; v.r = r; v.rt = rt; v.s = s; v.sp = sp; v.rs = rs; v.rp = rp;
        v.av = av; v.tag = tag; v.cnt = cnt; v.e = e;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit a, input bit r, input int rt, input bit s, input int sp,
                         input bit rs, input int rp);
        alloc_req     = a;
        release_valid = r;
        release_tag   = rt[7:0];
        save_state    = s;
        save_page     = sp[2:0];
        restore_state = rs;
        restore_page  = rp[2:0];
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        for (int i = 1; i <= 222; i++) begin
            @(posedge clk);
            #1;
            if (i == 221) begin
                chk({tag, "_ready_221"}, ready, 0);
                chk({tag, "_av_221"}, alloc_valid, 0);
            end
            if (i == 222) chk({tag, "_ready_222"}, ready, 1);
        end
    endtask

    // Behavioural model: unbounded head/tail counters into a tag ring.
    int m_mem[256];
    int m_head, m_tail, m_idx, m_cnt;
    bit m_run, m_err;
    int m_page[8];
    bit m_pv[8];

    function automatic int m512(input int x);
        return ((x % 512) + 512) % 512;
    endfunction

    function automatic int m_occ();
        int d = m512(m_tail - m_head);
        return (d > 256) ? 256 : d;
    endfunction

    task automatic model_reset();
        m_head = 0; m_tail = 0; m_idx = 0; m_cnt = 0; m_run = 0; m_err = 0;
        for (int i = 0; i < 8; i++) m_pv[i] = 0;
    endtask

    task automatic model_compare();
        int occ = m_occ();
        bit av  = m_run && (occ != 0);
        chk("rnd_ready", ready, m_run);
        chk("rnd_av", alloc_valid, av);
        if (av) chk("rnd_tag", alloc_tag, m_mem[m_head % 256]);
        chk("rnd_count", count, m_cnt);
        chk("rnd_err", err, m_err);
    endtask

    task automatic model_step(input bit a, input bit r, input int rt, input bit s, input int sp,
                              input bit rs, input int rp);
        int occ = m_occ();
        bit av  = m_run && (occ != 0);
        bit rest_ok  = m_run && rs && m_pv[rp];
        bit alloc_ok = a && av && !rest_ok;
        bit drop     = (rt == 0) || (rt == 254) || (rt == 255);
        if (a && !av && !rest_ok) m_err = 1;
        if (r) begin
            if (!m_run) m_err = 1;
            else if (!drop) begin
                if (occ == 256) m_err = 1;
                else begin
                    m_mem[m_tail % 256] = rt;
                    m_tail++;
                end
            end
        end
        if (s && rs) m_err = 1;
        else if (s && m_run) begin
            m_page[sp] = m_head + int'(alloc_ok);
            m_pv[sp]   = 1;
        end
        if (m_run && rs && !m_pv[rp]) m_err = 1;
        if (rest_ok) begin
            m_head = m_page[rp];
            if (m512(m_tail - m_head) > 256) m_err = 1;
        end else begin
            m_head += int'(alloc_ok);
        end
        if (!m_run) begin
            m_mem[m_idx] = 32 + m_idx;
            m_idx++;
            if (m_idx == 222) begin
                m_run  = 1;
                m_tail = 222;
            end
        end
        m_cnt = occ;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        idle();

        // Reset values and power-up fill.
        do_reset();
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_av", alloc_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        wait_init("init");

        // Directed vectors: allocs, release, save/alloc/restore.
        vt[0]  = mk(0, 0, 0,  0, 0, 0, 0, 1, 32, 0,   0);
        vt[1]  = mk(1, 0, 0,  0, 0, 0, 0, 1, 32, 222, 0);
        vt[2]  = mk(1, 0, 0,  0, 0, 0, 0, 1, 33, 222, 0);
        vt[3]  = mk(1, 0, 0,  0, 0, 0, 0, 1, 34, 221, 0);
        vt[4]  = mk(0, 0, 0,  0, 0, 0, 0, 1, 35, 220, 0);
        vt[5]  = mk(0, 1, 33, 0, 0, 0, 0, 1, 35, 219, 0);
        vt[6]  = mk(0, 0, 0,  0, 0, 0, 0, 1, 35, 219, 0);
        vt[7]  = mk(0, 0, 0,  0, 0, 0, 0, 1, 35, 220, 0);
        vt[8]  = mk(1, 0, 0,  0, 0, 0, 0, 1, 35, 220, 0);
        vt[9]  = mk(1, 0, 0,  0, 0, 0, 0, 1, 36, 220, 0);
        vt[10] = mk(1, 0, 0,  0, 0, 0, 0, 1, 37, 219, 0);
        vt[11] = mk(1, 0, 0,  0, 0, 0, 0, 1, 38, 218, 0);
        vt[12] = mk(1, 0, 0,  0, 0, 0, 0, 1, 39, 217, 0);
        vt[13] = mk(1, 0, 0,  1, 2, 0, 0, 1, 40, 216, 0);
        vt[14] = mk(1, 0, 0,  0, 0, 0, 0, 1, 41, 215, 0);
        vt[15] = mk(1, 0, 0,  0, 0, 0, 0, 1, 42, 214, 0);
        vt[16] = mk(1, 0, 0,  0, 0, 0, 0, 1, 43, 213, 0);
        vt[17] = mk(1, 0, 0,  0, 0, 0, 0, 1, 44, 212, 0);
        vt[18] = mk(1, 0, 0,  0, 0, 0, 0, 1, 45, 211, 0);
        vt[19] = mk(1, 0, 0,  0, 0, 1, 2, 1, 46, 210, 0);
        vt[20] = mk(0, 0, 0,  0, 0, 0, 0, 1, 41, 209, 0);
        vt[21] = mk(0, 0, 0,  0, 0, 0, 0, 1, 41, 214, 0);
        for (int v = 0; v < 22; v++) begin
            @(negedge clk);
            drive(vt[v].a, vt[v].r, vt[v].rt, vt[v].s, vt[v].sp, vt[v].rs, vt[v].rp);
            #1;
            chk($sformatf("vec%0d_av", v), alloc_valid, vt[v].av);
            if (vt[v].av) chk($sformatf("vec%0d_tag", v), alloc_tag, vt[v].tag);
            chk($sformatf("vec%0d_count", v), count, vt[v].cnt);
            chk($sformatf("vec%0d_err", v), err, vt[v].e);
        end

        // Drain: 41..253, then the released 33, then empty.
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            idle();
            #1;
            if (!alloc_valid) break;
            chk("drain_tag", alloc_tag, (n < 213) ? 41 + n : 33);
            alloc_req = 1'b1;
            n++;
        end
        chk("drain_len", n, 214);
        chk("empty_av", alloc_valid, 0);

        // Release into empty list: visible only the next cycle.
        drive(0, 1, 7, 0, 0, 0, 0);
        #1;
        chk("rel7_same_av", alloc_valid, 0);
        @(negedge clk);
        idle();
        #1;
        chk("rel7_next_av", alloc_valid, 1);
        chk("rel7_next_tag", alloc_tag, 7);
        drive(0, 1, 255, 0, 0, 0, 0);
        @(negedge clk);
        idle();
        #1;
        chk("rel255_err", err, 0);
        chk("rel255_av", alloc_valid, 1);
        chk("rel255_tag", alloc_tag, 7);
        chk("rel255_count", count, 1);

        // Restore of an unsaved page, then restore beating a same-cycle alloc.
        drive(0, 0, 0, 0, 0, 1, 5);
        @(negedge clk);
        idle();
        #1;
        chk("badpage_err", err, 1);
        chk("badpage_tag", alloc_tag, 7);
        chk("badpage_av", alloc_valid, 1);
        drive(1, 0, 0, 0, 0, 1, 2);
        @(negedge clk);
        idle();
        #1;
        chk("restalloc_tag", alloc_tag, 41);
        chk("restalloc_av", alloc_valid, 1);
        @(negedge clk);
        #1;
        chk("restalloc_count", count, 215);

        // Reset in the middle of INIT restarts the fill.
        do_reset();
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midinit_ready", ready, 0);
        chk("midinit_err", err, 0);
        chk("midinit_count", count, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_init("reinit");

        // Randomized run against the model: clean traffic, then protocol abuse.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit a = 0, r = 0, s = 0, rs = 0;
            int rt = 0, sp = 0, rp = 0;
            bit wild = (cyc > 1300);
            int occ = m_occ();
            if (m_run) begin
                a  = ($urandom_range(0, 99) < 55);
                if (!wild && occ == 0) a = 0;
                r  = ($urandom_range(0, 99) < 45);
                if (wild) rt = $urandom_range(0, 255);
                else if ($urandom_range(0, 9) == 0) rt = ($urandom_range(0, 2) == 0) ? 0 : 253 + $urandom_range(1, 2);
                else rt = $urandom_range(1, 253);
                if (!wild && occ == 256) r = 0;
                s  = ($urandom_range(0, 99) < 5);
                sp = $urandom_range(0, 7);
                rs = ($urandom_range(0, 99) < 3);
                rp = $urandom_range(0, 7);
                if (!wild && (!m_pv[rp] || s)) rs = 0;
            end
            drive(a, r, rt, s, sp, rs, rp);
            #1;
            model_compare();
            model_step(a, r, rt, s, sp, rs, rp);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
